systolic_feeder: RTL
====================

Name: systolic_feeder

Overview:
Operand sequencer and skew feeder that drives the DIM x DIM systolic_array. It accepts one k-slice per beat over a valid/ready stream: column k of A and row k of B. It emits diagonally skewed operands on the array's A row inputs and B column inputs. It also generates the array's clr and st controls, so that each PE accumulates one element of C = A x B.

Parameters:
N, 32, operand width in bits (matches the PE datapath)
DIM, 5, array dimension (rows = columns = DIM)
KW, 8, width of the k-length field; maximum inner dimension is 2^KW-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a job; sampled only in IDLE
k_len  input  KW  inner dimension K; sampled with start
in_valid  input  1  slice beat valid
in_ready  output  1  feeder accepts a beat this cycle
in_a  input  DIM*N  A[i][k] for i=0..DIM-1; lane i at bits [i*N +: N]
in_b  input  DIM*N  B[k][j] for j=0..DIM-1; lane j at bits [j*N +: N]
a_out  output  DIM*N  to array A0..A(DIM-1), skewed
b_out  output  DIM*N  to array B0..B(DIM-1), skewed
clr  output  1  to array clr
st  output  1  to array st
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, asserted the cycle after st

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n.
- Reset values: a_out=0, b_out=0, clr=0, st=0, busy=0, done=0, in_ready=0. All skew registers are 0 and the state is IDLE.
- All outputs are registered.
- States: IDLE, CLEAR, STREAM, DRAIN, STORE, DONE.
- IDLE:
  - start=1 latches k_len into kcnt and moves to CLEAR.
  - start while busy is ignored.
- CLEAR:
  - clr=1 for exactly one cycle; a_out and b_out are 0.
  - Next state is STREAM if kcnt!=0, else STORE.
- STREAM:
  - in_ready=1.
  - A beat is accepted when in_valid & in_ready; kcnt is decremented on each accepted beat.
  - A cycle with in_valid=0 is a bubble: zeros are injected into lane 0 of both skew chains. A bubble is harmless because 0*0 adds nothing and alignment is preserved.
  - in_ready drops in the cycle after the last beat is accepted; the state then moves to DRAIN.
- Skew:
  - Lane i of A and lane j of B pass through i (resp. j) register stages after the input register.
  - A beat accepted in cycle t appears on a_out lane i at t+1+i, and on b_out lane j at t+1+j.
- DRAIN:
  - Zeros are fed for exactly 2*DIM-1 cycles, counted by dcnt. This flushes the skew chains plus the DIM-1 PE hops to PE(DIM-1,DIM-1).
  - in_ready=0.
- STORE: st=1 for one cycle; clr=0.
- DONE: done=1 for one cycle, then the state returns to IDLE.
- clr and st are never asserted together.
- Outside STREAM, in_valid is ignored and no data is consumed.
- Skew chains shift every cycle in every state, with zero input outside accepted beats.
- Reset mid-operation: an immediate return to IDLE. No st or done is issued, and the skew chains are zeroed.
- Job duration with no bubbles: 1 (CLEAR) + K + (2*DIM-1) + 1 (STORE) + 1 (DONE) cycles from the start-accept edge.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_ABORT_EN
- Defined:
  - Adds an input port abort (1 bit).
  - abort=1 in any non-IDLE state moves to IDLE at the next edge.
  - The skew chains are zeroed. clr, st and done are not asserted, and in_ready drops the next cycle.
  - abort in IDLE has no effect.
  - abort takes priority over start and beat acceptance in the same cycle.
- Undefined: the abort port does not exist, and jobs always run to DONE unless rst_n is asserted.

Test Plan:
- Full job: DIM=5, K=3, in_valid held high, beats A column k=(k+1,k+2,..), B row k=(1,1,1,1,1) -> clr one cycle after start accept; beat 0 on a_out lane 4 exactly 5 cycles after acceptance; st asserted 1+3+9 cycles after CLEAR; done the next cycle. A reference array model yields C[i][j]=sum_k A[i][k].
- Bubbles: same job with in_valid low on alternate cycles -> identical C; busy stays high 3 cycles longer; skew alignment holds (lane i lags lane 0 by exactly i cycles).
- K=0: start with k_len=0 -> CLEAR, then STORE directly; in_ready never asserts; st asserted 2 cycles after start accept.
- Protocol: in_valid=1 in IDLE and DRAIN -> in_ready=0, nothing consumed; start during STREAM -> ignored, kcnt unchanged.
- Reset mid-STREAM after 2 of 4 beats, rst_n low for one cycle -> all outputs 0 asynchronously; no st or done; a new job afterwards completes correctly.
- With SYSTOLIC_FEEDER_ABORT_EN: abort in DRAIN -> IDLE next cycle, st and done never assert, a_out and b_out are 0 the following cycle.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand sequencer and diagonal skew feeder for a DIM x DIM systolic array.
// Optional abort input is compiled in when SYSTOLIC_FEEDER_ABORT_EN is defined.
module systolic_feeder #(
    parameter int N   = 32,
    parameter int DIM = 5,
    parameter int KW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KW-1:0]    k_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIM*N-1:0] in_a,
    input  logic [DIM*N-1:0] in_b,
    output logic [DIM*N-1:0] a_out,
    output logic [DIM*N-1:0] b_out,
    output logic             clr,
    output logic             st,
    output logic             busy,
    output logic             done
`ifdef SYSTOLIC_FEEDER_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int DCW = $clog2(2 * DIM);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * DIM - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  kcnt_q, kcnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           in_ready_q, clr_q, st_q, busy_q, done_q;
    logic           flush;
    logic           abort_w;
    logic           accept;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // in_valid/in_ready: a beat transfers on a cycle where both are high; abort wins over transfer.
    assign accept = in_ready_q & in_valid & ~abort_w;

    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        dcnt_d  = dcnt_q;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kcnt_d  = k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = (kcnt_q != '0) ? S_STREAM : S_STORE;
            S_STREAM: begin
                if (accept) begin
                    kcnt_d = kcnt_q - 1'b1;
                    if (kcnt_q == KW'(1)) begin
                        state_d = S_DRAIN;
                        dcnt_d  = DRAIN_LAST;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0) state_d = S_STORE;
                else              dcnt_d  = dcnt_q - 1'b1;
            end
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_w && state_q != S_IDLE) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end
    end

    // Control outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            kcnt_q     <= '0;
            dcnt_q     <= '0;
            in_ready_q <= 1'b0;
            clr_q      <= 1'b0;
            st_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kcnt_q     <= kcnt_d;
            dcnt_q     <= dcnt_d;
            in_ready_q <= (state_d == S_STREAM);
            clr_q      <= (state_d == S_CLEAR);
            st_q       <= (state_d == S_STORE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign in_ready = in_ready_q;
    assign clr      = clr_q;
    assign st       = st_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Lane i carries i+1 stages so its operand lands i cycles behind lane 0.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [N-1:0] a_sr_q [0:i];
        logic [N-1:0] b_sr_q [0:i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) begin
                    a_sr_q[s] <= '0;
                    b_sr_q[s] <= '0;
                end
            end else if (flush) begin
                for (int s = 0; s <= i; s++) begin
                    a_sr_q[s] <= '0;
                    b_sr_q[s] <= '0;
                end
            end else begin
                a_sr_q[0] <= accept ? in_a[i*N +: N] : '0;
                b_sr_q[0] <= accept ? in_b[i*N +: N] : '0;
                for (int s = 1; s <= i; s++) begin
                    a_sr_q[s] <= a_sr_q[s-1];
                    b_sr_q[s] <= b_sr_q[s-1];
                end
            end
        end

        assign a_out[i*N +: N] = a_sr_q[i];
        assign b_out[i*N +: N] = b_sr_q[i];
    end

endmodule
